// File: rtl/macs_sched_rr.sv
// macs_sched_rr: round-robin burst scheduler sharing the MAC array stream port between two requesters.
// Results return to their owner via a tag FIFO; define MACS_SCHED_STATS_EN for beat/stall counters.
module macs_sched_rr #(
  parameter int MAX_BURST = 16,
  parameter int TAG_DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s0_tvalid,
  output logic         s0_tready,
  input  logic [127:0] s0_tdata,
  input  logic         s0_tlast,
  input  logic         s1_tvalid,
  output logic         s1_tready,
  input  logic [127:0] s1_tdata,
  input  logic         s1_tlast,
  output logic         mac_s_tvalid,
  input  logic         mac_s_tready,
  output logic [127:0] mac_s_tdata,
  input  logic [127:0] mac_m_tdata,
  input  logic [7:0]   mac_m_tvalid,
  output logic         mac_m_tready,
  output logic [127:0] r0_tdata,
  output logic [127:0] r1_tdata,
  output logic         r0_tvalid,
  output logic         r1_tvalid,
  input  logic         r0_tready,
  input  logic         r1_tready,
  output logic [1:0]   err
`ifdef MACS_SCHED_STATS_EN
  ,
  output logic [31:0]  beats0,
  output logic [31:0]  beats1,
  output logic [31:0]  stall_cyc
`endif
);
  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic [1:0] {IDLE, G0, G1} state_t;
  state_t state_q, state_d;
  logic rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TAG_DEPTH-1:0] tag_q, tag_d;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [PW:0] fill_q, fill_d;
  logic [1:0] err_q, err_d;
  logic gnt0, gnt1, full, empty, head, accept, pop, res_v, partial, head_rdy, burst_end, want;
  always_comb begin
    gnt0 = state_q == G0;
    gnt1 = state_q == G1;
    full = fill_q == (PW+1)'(TAG_DEPTH);
    empty = fill_q == '0;
    head = tag_q[rp_q];
    want = (gnt0 & s0_tvalid) | (gnt1 & s1_tvalid);
    mac_s_tvalid = want & !full;
    mac_s_tdata = gnt0 ? s0_tdata : gnt1 ? s1_tdata : '0;
    s0_tready = gnt0 & mac_s_tready & !full;
    s1_tready = gnt1 & mac_s_tready & !full;
    accept = mac_s_tvalid & mac_s_tready;
    burst_end = (gnt1 ? s1_tlast : s0_tlast) | (cnt_q == CW'(MAX_BURST - 1));
    res_v = &mac_m_tvalid;
    partial = |mac_m_tvalid & !res_v;
    head_rdy = head ? r1_tready : r0_tready;
    r0_tvalid = !empty & !head & res_v;
    r1_tvalid = !empty & head & res_v;
    r0_tdata = (!empty & !head) ? mac_m_tdata : '0;
    r1_tdata = (!empty & head) ? mac_m_tdata : '0;
    // With no owner on record the beat is an orphan and is drained immediately
    mac_m_tready = reset & (empty | (head_rdy & !partial));
    pop = !empty & res_v & head_rdy;
    state_d = state_q;
    rr_d = rr_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: begin
        if (s0_tvalid & !(s1_tvalid & rr_q)) begin
          state_d = G0;
          rr_d = 1'b1;
        end else if (s1_tvalid) begin
          state_d = G1;
          rr_d = 1'b0;
        end
      end
      default: begin
        if (accept) begin
          state_d = burst_end ? IDLE : state_q;
          cnt_d = burst_end ? '0 : cnt_q + CW'(1);
        end
      end
    endcase
    tag_d = tag_q;
    if (accept) tag_d[wp_q] = gnt1;
    wp_d = wp_q + PW'(accept);
    rp_d = rp_q + PW'(pop);
    fill_d = fill_q + (PW+1)'(accept) - (PW+1)'(pop);
    err_d = err_q | {empty & res_v, partial};
  end
  assign err = err_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rr_q <= 1'b0;
      cnt_q <= '0;
      tag_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      fill_q <= '0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      cnt_q <= cnt_d;
      tag_q <= tag_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      fill_q <= fill_d;
      err_q <= err_d;
    end
  end
`ifdef MACS_SCHED_STATS_EN
  logic [31:0] beats0_q, beats0_d, beats1_q, beats1_d, stall_q, stall_d;
  always_comb begin
    beats0_d = beats0_q + 32'(accept & gnt0);
    beats1_d = beats1_q + 32'(accept & gnt1);
    stall_d = stall_q + 32'(want & !accept);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beats0_q <= '0;
      beats1_q <= '0;
      stall_q <= '0;
    end else begin
      beats0_q <= beats0_d;
      beats1_q <= beats1_d;
      stall_q <= stall_d;
    end
  end
  assign beats0 = beats0_q;
  assign beats1 = beats1_q;
  assign stall_cyc = stall_q;
`endif
endmodule

// File: doc/macs_sched_rr.md
Name: macs_sched_rr

Overview:
- Round-robin scheduler that shares the 8-lane MAC array stream port between two requesters, e.g. two neuron-layer engines.
- Grants are burst-granular: a burst ends on tlast or at MAX_BURST beats.
- Each accepted input beat gets an owner tag in a tag FIFO. Each MAC result beat returns to the requester that issued it, in order.
- The block sits between the requester engines and the MAC array's s_axis/m_axis ports.

Parameters:
- MAX_BURST, 16, beats per grant before forced release (>=1).
- TAG_DEPTH, 8, tag FIFO entries; this is the maximum number of in-flight beats (power of 2, >=2).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- s0_tvalid  in  1  requester 0 beat valid
- s0_tready  out  1  requester 0 beat accepted
- s0_tdata  in  128  requester 0 packed {weight,data} x8
- s0_tlast  in  1  requester 0 end of burst
- s1_tvalid, s1_tready, s1_tdata, s1_tlast  as s0, for requester 1
- mac_s_tvalid  out  1  to MAC array input valid
- mac_s_tready  in  1  MAC array input ready
- mac_s_tdata  out  128  to MAC array input data
- mac_m_tdata  in  128  MAC array results
- mac_m_tvalid  in  8  per-lane result valid
- mac_m_tready  out  1  result accept to MAC array
- r0_tdata, r1_tdata  out  128  routed results
- r0_tvalid, r1_tvalid  out  1  routed result valid
- r0_tready, r1_tready  in  1  requester result ready
- err  out  2  sticky: [0] partial lane valid, [1] orphan result

Behaviour:
- Reset (reset=0, async):
  - FSM=IDLE, rr pointer=0, beat count=0, tag FIFO empty, err=0.
  - All tvalid/tready outputs are 0; data outputs are 0.
  - A reset mid-burst flushes in-flight tags; any later results are treated as orphans.
- FSM states IDLE, G0, G1:
  - IDLE, only s0_tvalid set -> G0. Only s1_tvalid set -> G1. Both set -> the requester the rr pointer names. Neither -> stay in IDLE.
  - On entering Gk, the rr pointer is set to !k.
  - In Gk, release happens on the accepted beat that has tlast=1 or is the MAX_BURST-th beat. Release -> IDLE, beat count cleared.
  - There is one IDLE bubble cycle between grants; this is required and testable.
- Input forwarding (combinational) in Gk:
  - mac_s_tvalid = sk_tvalid & !tag_full.
  - mac_s_tdata = sk_tdata.
  - sk_tready = mac_s_tready & !tag_full.
  - The non-granted requester's tready = 0. In IDLE all treadies are 0 and mac_s_tvalid = 0.
- Accept = mac_s_tvalid & mac_s_tready. On accept, push tag k.
- tag_full blocks the push even if a pop happens in the same cycle.
- Result beat:
  - res_v = (mac_m_tvalid == 8'hFF).
  - If mac_m_tvalid is nonzero and not all-ones, set err[0]. That beat is not consumed until all lanes are valid.
- Routing with FIFO non-empty and head = h:
  - rh_tvalid = res_v; rh_tdata = mac_m_tdata; mac_m_tready = rh_tready.
  - The other requester's tvalid = 0.
  - Pop when res_v & rh_tready.
- Routing with FIFO empty:
  - mac_m_tready = 1; beat dropped.
  - If res_v, set err[1].
  - r*_tvalid = 0.
- Simultaneous push and pop (not full): count unchanged, order preserved.
- r*_tdata may hold stale data when r*_tvalid = 0.
- Latency:
  - 0 cycles input -> MAC.
  - 0 cycles MAC result -> requester.
  - Grant takes effect 1 cycle after tvalid is seen in IDLE.

Optional Feature:
- Macro MACS_SCHED_STATS_EN.
- When defined, three extra outputs are added:
  - beats0 [31:0] and beats1 [31:0]: accepted input beats per requester.
  - stall_cyc [31:0]: cycles with a granted tvalid=1 but no accept.
  - All three wrap at 2^32, reset to 0, and are cleared only by reset.
- When undefined, these ports and counters are absent and there is no other behavioural change.

Test Plan:
- Single requester: s0 sends 3 beats with tlast on beat 3, mac_s_tready=1 -> mac_s_tdata equals s0 data each cycle; FSM G0 -> IDLE after beat 3. Results 8'hFF x3 -> r0_tvalid x3 with matching data; r1_tvalid stays 0.
- Contention: s0 and s1 both valid from reset, bursts of 2 -> grant order s0, s0, bubble, s1, s1, bubble, s0. Results are routed to owners in that order.
- Forced release: MAX_BURST=16, s1 holds tlast=0 for 20 beats, s0 pending -> s1 is released after beat 16; s0 is granted after the bubble.
- Backpressure/full: TAG_DEPTH=8, mac_m_tvalid=0 -> after 8 accepts sk_tready=0. One result with r_tready=1 pops a tag -> the next input is accepted the following cycle.
- Errors: mac_m_tvalid=8'h0F -> err=2'b01 and mac_m_tready=0 while the FIFO is non-empty. Then reset, then mac_m_tvalid=8'hFF with the FIFO empty -> err=2'b10 and the beat is dropped.
- Reset mid-burst: reset low during G1 with 3 tags outstanding -> s1_tready=0 immediately; after release, returning results set err[1].
